// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the sequential ALU: the 4-bit opcode encodings and
// the controller state type used by alu_seq.
//
// Configuration macro: ALU_SEQ_MUL_EN
//   Defined   -> the MUL state exists and opcode 1101 runs the multi-cycle
//                shift-add multiplier.
//   Undefined -> the state type has no MUL member.
// ---------------------------------------------------------------------------
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOR = 4'b0110;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_SHR = 4'b1000;
    localparam logic [3:0] OP_ASR = 4'b1001;
    localparam logic [3:0] OP_ROL = 4'b1010;
    localparam logic [3:0] OP_ROR = 4'b1011;
    localparam logic [3:0] OP_EQ  = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1101;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        HOLD = 2'b10
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b10
    } state_t;
`endif

endpackage

// File: rtl/alu_seq_comb.sv
// ---------------------------------------------------------------------------
// alu_seq_comb
// Purely combinational datapath for every single-cycle opcode (0000-1100).
// Opcodes 1101-1111 produce zero here; the multiply, when enabled, is done
// by the sequencer in alu_seq.
//
// Ports:
//   ctrl_i   [3:0]       opcode
//   x_i      [WIDTH-1:0] operand x (also the shift amount source)
//   y_i      [WIDTH-1:0] operand y
//   result_o [WIDTH-1:0] computed result
//   carry_o              carry for add, borrow for sub, zero otherwise
// ---------------------------------------------------------------------------
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o
);

    logic [WIDTH:0] sumWide;
    logic [WIDTH:0] diffWide;

    // One extra bit on add/sub: for the subtraction the top bit of the
    // WIDTH+1 bit difference is set exactly when x < y, i.e. the borrow.
    always_comb begin
        sumWide  = {1'b0, x_i} + {1'b0, y_i};
        diffWide = {1'b0, x_i} - {1'b0, y_i};
    end

    // Opcode decode. Only add and sub drive carry; every other opcode,
    // including the reserved ones, leaves it at zero.
    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        case (ctrl_i)
            OP_ADD: {carry_o, result_o} = sumWide;
            OP_SUB: {carry_o, result_o} = diffWide;
            OP_AND: result_o = x_i & y_i;
            OP_OR:  result_o = x_i | y_i;
            OP_NOT: result_o = ~x_i;
            OP_XOR: result_o = x_i ^ y_i;
            OP_NOR: result_o = ~(x_i | y_i);
            OP_SHL: result_o = y_i << x_i[SHW-1:0];
            OP_SHR: result_o = y_i >> x_i[SHW-1:0];
            OP_ASR: result_o = WIDTH'($signed(x_i) >>> 1);
            OP_ROL: result_o = {x_i[WIDTH-2:0], x_i[WIDTH-1]};
            OP_ROR: result_o = {x_i[0], x_i[WIDTH-1:1]};
            OP_EQ:  result_o = {{(WIDTH-1){1'b0}}, (x_i == y_i)};
            default: begin
                result_o = '0;
                carry_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Handshaked sequential ALU. One operation is accepted at a time; the result
// is registered and held until the consumer takes it. A new operation may be
// accepted on the same edge the previous result is consumed.
//
// Configuration macro: ALU_SEQ_MUL_EN
//   Defined   -> opcode 1101 is an unsigned shift-add multiply taking WIDTH
//                cycles in the MUL state.
//   Undefined -> opcode 1101 is a single-cycle op giving zero; no multiplier.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake
//   ctrl, x, y           opcode and operands
//   out_valid/out_ready  result handshake
//   out, carry           registered result and carry/flag
// ---------------------------------------------------------------------------
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry
);

    state_t           state_q;
    logic [WIDTH-1:0] out_q;
    logic             carry_q;
    logic             outValid_q;

    logic [WIDTH-1:0] aluResult_d;
    logic             aluCarry_d;
    logic             accept;
    logic             consume;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mulAcc_q;
    logic [2*WIDTH-1:0] mulCand_q;
    logic [WIDTH-1:0]   mulPlier_q;
    logic [CW-1:0]      mulCnt_q;
    logic [2*WIDTH-1:0] mulAcc_d;
`endif

    alu_seq_comb #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_comb (
        .ctrl_i   (ctrl),
        .x_i      (x),
        .y_i      (y),
        .result_o (aluResult_d),
        .carry_o  (aluCarry_d)
    );

    // While a result is held, we can take a new operation only if the
    // current one leaves on the same edge, so in_ready follows out_ready.
    // Reset forces in_ready low immediately, not just after the edge.
    always_comb begin
        in_ready = !rst && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
        accept   = in_valid && in_ready;
        consume  = outValid_q && out_ready;
    end

`ifdef ALU_SEQ_MUL_EN
    // Next accumulator value: add the shifted multiplicand when the current
    // multiplier LSB is set. On the final bit this is the full product.
    always_comb begin
        mulAcc_d = mulAcc_q + (mulPlier_q[0] ? mulCand_q : '0);
    end
`endif

    // Controller. Operands are captured at acceptance (into out_q for
    // single-cycle ops, into the multiplier registers for MUL), so later
    // changes on x/y/ctrl cannot disturb an operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            out_q      <= '0;
            carry_q    <= 1'b0;
            outValid_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mulAcc_q   <= '0;
            mulCand_q  <= '0;
            mulPlier_q <= '0;
            mulCnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                        if (ctrl == OP_MUL) begin
                            state_q    <= MUL;
                            outValid_q <= 1'b0;
                            mulAcc_q   <= '0;
                            mulCand_q  <= {{WIDTH{1'b0}}, x};
                            mulPlier_q <= y;
                            mulCnt_q   <= '0;
                        end else begin
                            state_q    <= HOLD;
                            outValid_q <= 1'b1;
                            out_q      <= aluResult_d;
                            carry_q    <= aluCarry_d;
                        end
`else
                        state_q    <= HOLD;
                        outValid_q <= 1'b1;
                        out_q      <= aluResult_d;
                        carry_q    <= aluCarry_d;
`endif
                    end else if (consume) begin
                        state_q    <= IDLE;
                        outValid_q <= 1'b0;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                // One multiplier bit per cycle; the WIDTH-th MUL cycle
                // writes the product and raises out_valid.
                MUL: begin
                    mulAcc_q   <= mulAcc_d;
                    mulCand_q  <= mulCand_q << 1;
                    mulPlier_q <= mulPlier_q >> 1;
                    mulCnt_q   <= mulCnt_q + 1'b1;
                    if (mulCnt_q == CW'(WIDTH - 1)) begin
                        state_q    <= HOLD;
                        outValid_q <= 1'b1;
                        out_q      <= mulAcc_d[WIDTH-1:0];
                        carry_q    <= |mulAcc_d[2*WIDTH-1:WIDTH];
                    end
                end
`endif
                default: begin
                    state_q    <= IDLE;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        out_valid = outValid_q;
        out       = out_q;
        carry     = carry_q;
    end

endmodule
